// File: rtl/key_step_debouncer_if.sv
// Handshake bundle between the raw step key and the debounced step outputs.
// The master drives the key and the slave produces step, pressed and step_count.
interface key_step_debouncer_if;
    logic        key_n;
    logic        step;
    logic        pressed;
    logic [15:0] step_count;

    modport master (output key_n, input step, pressed, step_count);
    modport slave  (input key_n, output step, pressed, step_count);
endinterface

// File: rtl/key_step_debouncer.sv
// Single-step key conditioner: 2-FF synchronizer, counter-based debounce FSM,
// one-cycle step pulse per accepted press plus optional hold-to-auto-repeat.
module key_step_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int REPEAT_EN       = 1,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 5000000
) (
    input logic                  clock,
    input logic                  reset,
    key_step_debouncer_if.slave  bus
);

    localparam int MAX_DR  = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
    localparam int MAX_ALL = (MAX_DR > REPEAT_PERIOD) ? MAX_DR : REPEAT_PERIOD;
    localparam int CNT_W   = $clog2(MAX_ALL);

    localparam logic [CNT_W-1:0] DEB_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DELAY_LAST  = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] PERIOD_LAST = CNT_W'(REPEAT_PERIOD - 1);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    state_t           state;
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] rpt;
    logic             repeated;
    logic             step_q;
    logic             pressed_q;
    logic [15:0]      count_q;

    logic sync_n;
    assign sync_n = s2;

    // NOTE: every register here uses <= so s2 captures the old s1, and the FSM
    // sees sync_n from before this edge; blocking assigns would collapse the chain.
    always_ff @(posedge clock) begin
        if (reset) begin
            s1        <= 1'b1;
            s2        <= 1'b1;
            state     <= IDLE;
            cnt       <= '0;
            rpt       <= '0;
            repeated  <= 1'b0;
            step_q    <= 1'b0;
            pressed_q <= 1'b0;
            count_q   <= '0;
        end else begin
            s1     <= bus.key_n;
            s2     <= s1;
            step_q <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (!sync_n) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end

                PRESS_WAIT: begin
                    if (sync_n) begin
                        state <= IDLE;
                    end else if (cnt == DEB_LAST) begin
                        state     <= HELD;
                        step_q    <= 1'b1;
                        pressed_q <= 1'b1;
                        count_q   <= count_q + 16'd1;
                        rpt       <= '0;
                        repeated  <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                HELD: begin
                    if (sync_n) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end else if (REPEAT_EN != 0) begin
                        // First repeat waits the long delay, later ones the short period.
                        if (rpt == (repeated ? PERIOD_LAST : DELAY_LAST)) begin
                            step_q   <= 1'b1;
                            count_q  <= count_q + 16'd1;
                            rpt      <= '0;
                            repeated <= 1'b1;
                        end else begin
                            rpt <= rpt + 1'b1;
                        end
                    end
                end

                RELEASE_WAIT: begin
                    if (!sync_n) begin
                        state <= HELD;
                    end else if (cnt == DEB_LAST) begin
                        state     <= IDLE;
                        pressed_q <= 1'b0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.step       = step_q;
    assign bus.pressed    = pressed_q;
    assign bus.step_count = count_q;

endmodule

// File: tb/tb_key_step_debouncer.sv
// Directed bench for key_step_debouncer: one repeating and one non-repeating
// instance share the key; every edge of each window checks step and pressed.
module tb_key_step_debouncer;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    key_step_debouncer_if bus_a ();
    key_step_debouncer_if bus_b ();

    key_step_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (1),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus_a.slave)
    );

    key_step_debouncer #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_EN       (0),
        .REPEAT_DELAY    (10),
        .REPEAT_PERIOD   (3)
    ) dut_norep (
        .clock (clock),
        .reset (reset),
        .bus   (bus_b.slave)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [63:0] span(input int lo, input int hi);
        logic [63:0] m;
        m = '0;
        for (int i = lo; i <= hi; i++) m[i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] bit_at(input int e);
        logic [63:0] m;
        m    = '0;
        m[e] = 1'b1;
        return m;
    endfunction

    task automatic set_key(input logic v);
        bus_a.key_n = v;
        bus_b.key_n = v;
    endtask

    task automatic check_counts(input string tag, input logic [15:0] exp_a, input logic [15:0] exp_b);
        check({tag, " count_a"}, 32'(bus_a.step_count), 32'(exp_a));
        check({tag, " count_b"}, 32'(bus_b.step_count), 32'(exp_b));
    endtask

    // Starts and ends on a falling edge; the next rising edge is edge 0.
    task automatic do_reset();
        reset = 1'b1;
        set_key(1'b1);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        check("rst step_a", 32'(bus_a.step), 32'd0);
        check("rst pressed_a", 32'(bus_a.pressed), 32'd0);
        check("rst step_b", 32'(bus_b.step), 32'd0);
        check("rst pressed_b", 32'(bus_b.pressed), 32'd0);
        check_counts("rst", 16'h0000, 16'h0000);
    endtask

    // Drives the key for edges first..first+n-1 from low[] (1 = key pressed)
    // and checks both instances after each edge against the expected masks.
    task automatic run_window(input int tnum, input int first, input int n, input int rst_edge,
                              input logic [63:0] low, input logic [63:0] sa, input logic [63:0] pa,
                              input logic [63:0] sb, input logic [63:0] pb);
        for (int e = first; e < first + n; e++) begin
            set_key(!low[e]);
            reset = (e == rst_edge);
            @(posedge clock);
            @(negedge clock);
            check($sformatf("t%0d e%0d step_a", tnum, e), 32'(bus_a.step), 32'(sa[e]));
            check($sformatf("t%0d e%0d pressed_a", tnum, e), 32'(bus_a.pressed), 32'(pa[e]));
            check($sformatf("t%0d e%0d step_b", tnum, e), 32'(bus_b.step), 32'(sb[e]));
            check($sformatf("t%0d e%0d pressed_b", tnum, e), 32'(bus_b.pressed), 32'(pb[e]));
        end
        reset = 1'b0;
    endtask

    initial begin
        logic [63:0] low;
        logic [63:0] sa;

        set_key(1'b1);

        // Clean press: step after edge 6, release accepted after edge 14.
        do_reset();
        run_window(1, 0, 20, -1, span(0, 7), bit_at(6), span(6, 13), bit_at(6), span(6, 13));
        check_counts("t1", 16'd1, 16'd1);

        // Press bounce: low runs of 3 never outlast the debounce window.
        do_reset();
        low = '0;
        for (int e = 0; e < 30; e++) if ((e % 5) < 3) low[e] = 1'b1;
        run_window(2, 0, 40, -1, low, 64'd0, 64'd0, 64'd0, 64'd0);
        check_counts("t2", 16'd0, 16'd0);

        // Auto-repeat: first repeat 10 cycles after the step, then every 3.
        do_reset();
        sa = bit_at(6) | bit_at(16);
        for (int e = 19; e <= 40; e += 3) sa |= bit_at(e);
        run_window(3, 0, 50, -1, span(0, 39), sa, span(6, 45), bit_at(6), span(6, 45));
        check_counts("t3", 16'd10, 16'd1);

        // Release bounce while held; the repeat counter is frozen during it.
        do_reset();
        low = span(0, 9) | span(12, 19);
        run_window(4, 0, 35, -1, low, bit_at(6) | bit_at(19), span(6, 25), bit_at(6), span(6, 25));
        check_counts("t4", 16'd2, 16'd1);

        // Wrap: preload the repeating instance's counter just below the top.
        do_reset();
        sa = bit_at(6) | bit_at(16) | bit_at(19) | bit_at(22);
        run_window(5, 0, 8, -1, span(0, 63), sa, span(6, 63), bit_at(6), span(6, 63));
        check_counts("t5 pre", 16'd1, 16'd1);
        force dut.count_q = 16'hFFFD;
        #1;
        release dut.count_q;
        run_window(5, 8, 9, -1, span(0, 63), sa, span(6, 63), bit_at(6), span(6, 63));
        check_counts("t5 e16", 16'hFFFE, 16'd1);
        run_window(5, 17, 3, -1, span(0, 63), sa, span(6, 63), bit_at(6), span(6, 63));
        check_counts("t5 e19", 16'hFFFF, 16'd1);
        run_window(5, 20, 3, -1, span(0, 63), sa, span(6, 63), bit_at(6), span(6, 63));
        check_counts("t5 e22", 16'h0000, 16'd1);

        // Reset mid-hold at edge 20; the still-held key is a fresh press.
        do_reset();
        sa = bit_at(6) | bit_at(16) | bit_at(19);
        run_window(6, 0, 20, -1, span(0, 63), sa, span(6, 19), bit_at(6), span(6, 19));
        check_counts("t6 pre", 16'd3, 16'd1);
        run_window(6, 20, 1, 20, span(0, 63), 64'd0, 64'd0, 64'd0, 64'd0);
        check_counts("t6 rst", 16'd0, 16'd0);
        run_window(6, 21, 9, -1, span(0, 63), bit_at(27), span(27, 63), bit_at(27), span(27, 63));
        check_counts("t6 post", 16'd1, 16'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
